// File: rtl/ssc_pkg.sv
// Shared types and defaults for the sort-controller run sequencer.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package ssc_pkg;

  localparam int DW_DEF      = 8;
  localparam int DEPTH_DEF   = 256;
  localparam int TIMEOUT_DEF = 200000;
  localparam logic [DW_DEF-1:0] PAD_VALUE_DEF = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PAD,
    S_START,
    S_WAIT,
    S_RD,
    S_OUT
  } state_t;

  // Per-state output flags, registered alongside the state.
  typedef struct packed {
    logic in_ready;
    logic rf_own;
    logic busy;
    logic ssc_start;
    logic rf_re;
    logic out_valid;
  } flags_t;

  function automatic flags_t state_flags(input state_t s);
    flags_t f;
    f.in_ready  = (s == S_IDLE) || (s == S_LOAD);
    f.rf_own    = (s != S_START) && (s != S_WAIT);
    f.busy      = (s != S_IDLE);
    f.ssc_start = (s == S_START);
    f.rf_re     = (s == S_RD);
    f.out_valid = (s == S_OUT);
    return f;
  endfunction

endpackage

// File: rtl/ssc_run_sequencer_if.sv
// Bundle of load/result streams, register-file port and sort-controller handshake.
// Latency: n/a (wires only).
// Backpressure: in_ready / out_ready carry valid-ready flow control.
interface ssc_run_sequencer_if
  import ssc_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = $clog2(DEPTH_DEF)
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  logic          rf_own;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wdata;
  logic          rf_we;
  logic          rf_re;
  logic [DW-1:0] rf_rdata;

  logic          ssc_start;
  logic          ssc_done;
  logic          busy;
  logic          err_timeout;

  // Sequencer side.
  modport master (
    input  in_valid, in_data, in_last, out_ready, rf_rdata, ssc_done,
    output in_ready, out_valid, out_data, out_last,
           rf_own, rf_addr, rf_wdata, rf_we, rf_re,
           ssc_start, busy, err_timeout
  );

  // Environment side: stream source/sink, register file, sort controller.
  modport slave (
    output in_valid, in_data, in_last, out_ready, rf_rdata, ssc_done,
    input  in_ready, out_valid, out_data, out_last,
           rf_own, rf_addr, rf_wdata, rf_we, rf_re,
           ssc_start, busy, err_timeout
  );

endinterface

// File: rtl/ssc_watchdog.sv
// Cycle counter that flags expiry after TIMEOUT_CYCLES consecutive enabled cycles.
// Latency: expired is combinational, high during the TIMEOUT_CYCLES-th enabled cycle.
// Backpressure: none; clr restarts the count.
module ssc_watchdog
  import ssc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign expired = en & (cnt == LIMIT);

  // Count enabled cycles; saturate once expired so the flag cannot wrap away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en & ~expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ssc_run_sequencer.sv
// Loads a stream into the register file, pads it, runs the sort controller, streams count results back.
// Latency: load 1 beat/cycle (write same cycle); unload RD+OUT = 2 cycles per beat minimum.
// Backpressure: in_ready low outside IDLE/LOAD; OUT holds data/valid stable until out_ready.
module ssc_run_sequencer
  import ssc_pkg::*;
#(
  parameter int DW             = DW_DEF,
  parameter int DEPTH          = DEPTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter logic [DW-1:0] PAD_VALUE = PAD_VALUE_DEF
) (
  input logic clk,
  input logic rst,
  ssc_run_sequencer_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C   = (AW + 1)'(DEPTH);
  localparam logic [AW:0] LAST_ADDR = (AW + 1)'(DEPTH - 1);

  state_t        state;
  flags_t        fl;
  logic [AW:0]   count;     // elements loaded, 1..DEPTH
  logic [AW:0]   idx;       // pad pointer in PAD, read pointer in RD/OUT
  logic [AW:0]   count_inc;
  logic [AW:0]   count_m1;
  logic          last_q;
  logic          err_q;
  logic          fresh;     // first OUT cycle: read data arrives straight from the RF
  logic [DW-1:0] hold;
  logic          accept;
  logic          wd_en;
  logic          wd_expired;

  assign count_inc = count + 1'b1;
  assign count_m1  = count - 1'b1;
  assign accept    = fl.in_ready & bus.in_valid & ~rst;
  assign wd_en     = (state == S_WAIT);

  ssc_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .en     (wd_en),
    .clr    (~wd_en),
    .expired(wd_expired)
  );

  // Sequencer FSM: state, counters and registered per-state outputs move together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      fl     <= state_flags(S_IDLE);
      count  <= '0;
      idx    <= '0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
      fresh  <= 1'b0;
      hold   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            count <= (AW + 1)'(1);
            err_q <= 1'b0;
            if (bus.in_last) begin
              state <= S_PAD;
              fl    <= state_flags(S_PAD);
              idx   <= (AW + 1)'(1);
            end else begin
              state <= S_LOAD;
              fl    <= state_flags(S_LOAD);
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            count <= count_inc;
            // A full register file ends the load whatever in_last says.
            if (count_inc == DEPTH_C) begin
              state <= S_START;
              fl    <= state_flags(S_START);
            end else if (bus.in_last) begin
              state <= S_PAD;
              fl    <= state_flags(S_PAD);
              idx   <= count_inc;
            end
          end
        end
        S_PAD: begin
          idx <= idx + 1'b1;
          if (idx == LAST_ADDR) begin
            state <= S_START;
            fl    <= state_flags(S_START);
          end
        end
        S_START: begin
          state <= S_WAIT;
          fl    <= state_flags(S_WAIT);
        end
        S_WAIT: begin
          // A done pulse landing on the expiry cycle still counts as completion.
          if (bus.ssc_done) begin
            state <= S_RD;
            fl    <= state_flags(S_RD);
            idx   <= '0;
          end else if (wd_expired) begin
            state <= S_IDLE;
            fl    <= state_flags(S_IDLE);
            err_q <= 1'b1;
          end
        end
        S_RD: begin
          state  <= S_OUT;
          fl     <= state_flags(S_OUT);
          last_q <= (idx == count_m1);
          fresh  <= 1'b1;
        end
        S_OUT: begin
          if (fresh) begin
            hold  <= bus.rf_rdata;
            fresh <= 1'b0;
          end
          if (bus.out_ready) begin
            if (last_q) begin
              state  <= S_IDLE;
              fl     <= state_flags(S_IDLE);
              last_q <= 1'b0;
            end else begin
              state <= S_RD;
              fl    <= state_flags(S_RD);
              idx   <= idx + 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          fl    <= state_flags(S_IDLE);
        end
      endcase
    end
  end

  // Register-file port: loads write in the accepting cycle, padding one entry per cycle.
  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_addr  = '0;
    bus.rf_wdata = '0;
    case (state)
      S_IDLE: begin
        bus.rf_we    = accept;
        bus.rf_wdata = bus.in_data;
      end
      S_LOAD: begin
        bus.rf_we    = accept;
        bus.rf_addr  = count[AW-1:0];
        bus.rf_wdata = bus.in_data;
      end
      S_PAD: begin
        bus.rf_we    = 1'b1;
        bus.rf_addr  = idx[AW-1:0];
        bus.rf_wdata = PAD_VALUE;
      end
      S_RD: begin
        bus.rf_addr = idx[AW-1:0];
      end
      default: begin
      end
    endcase
  end

  assign bus.in_ready    = fl.in_ready;
  assign bus.rf_own      = fl.rf_own;
  assign bus.busy        = fl.busy;
  assign bus.ssc_start   = fl.ssc_start;
  assign bus.rf_re       = fl.rf_re;
  assign bus.out_valid   = fl.out_valid;
  assign bus.out_last    = last_q;
  assign bus.out_data    = fresh ? bus.rf_rdata : hold;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_ssc_run_sequencer.sv
// Scoreboard bench: loads push expected beats, the output monitor pops and compares.
// Latency: n/a.
// Backpressure: exercised via out_ready stalls.
module tb_ssc_run_sequencer;
  import ssc_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int TMO   = 500;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ssc_run_sequencer_if #(.DW(DW), .AW(AW)) bus ();

  ssc_run_sequencer #(
    .DW            (DW),
    .DEPTH         (DEPTH),
    .TIMEOUT_CYCLES(TMO),
    .PAD_VALUE     (8'hFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [7:0] mem  [DEPTH];
  logic [7:0] vals [DEPTH];
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  int checks    = 0;
  int failures  = 0;
  int start_cnt = 0;
  int we_cnt    = 0;
  int ovld_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Register file model: written/read only while the sequencer owns the port.
  always @(posedge clk) begin
    if (bus.rf_own && bus.rf_we) mem[bus.rf_addr] <= bus.rf_wdata;
    if (bus.rf_own && bus.rf_re) bus.rf_rdata <= mem[bus.rf_addr];
  end

  // Output monitor and activity counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      start_cnt = start_cnt + int'(bus.ssc_start);
      we_cnt    = we_cnt + int'(bus.rf_we);
      ovld_cnt  = ovld_cnt + int'(bus.out_valid);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", 32'(bus.out_data), 32'(mon_e[7:0]));
          check("out_last", 32'(bus.out_last), 32'(mon_e[8]));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n, input bit with_last, input int done_at);
    logic lst;
    for (int i = 0; i < n; i++) begin
      lst = (i == n - 1);
      bus.in_valid = 1'b1;
      bus.in_data  = vals[i];
      bus.in_last  = with_last && lst;
      bus.ssc_done = (i == done_at);
      @(negedge clk);
      check("load_in_ready", 32'(bus.in_ready), 32'd1);
      step();
      exp_q.push_back({lst, vals[i]});
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
    bus.ssc_done = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 1000 && !ok; c++) begin
      @(negedge clk);
      if (bus.ssc_start) ok = 1'b1;
    end
    step();
  endtask

  task automatic pulse_done(input int delay);
    repeat (delay - 1) step();
    @(negedge clk);
    check("wait_rf_own", 32'(bus.rf_own), 32'd0);
    check("wait_rf_we", 32'(bus.rf_we), 32'd0);
    step();
    bus.ssc_done = 1'b1;
    step();
    bus.ssc_done = 1'b0;
  endtask

  task automatic drain(input string tag);
    int c;
    for (c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.busy) break;
    end
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout got=stuck exp=finish");
    $fatal(1, "bench did not reach the end");
  end

  initial begin
    bit ok;
    int c, s0, w0, o0, bad;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    bus.ssc_done  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_rf_own", 32'(bus.rf_own), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_ssc_start", 32'(bus.ssc_start), 32'd0);
    check("rst_rf_we", 32'(bus.rf_we), 32'd0);
    check("rst_rf_re", 32'(bus.rf_re), 32'd0);
    check("rst_err", 32'(bus.err_timeout), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Short load with padding, sort done after 100 cycles.
    vals[0] = 8'd5; vals[1] = 8'd2; vals[2] = 8'd9;
    s0 = start_cnt; w0 = we_cnt;
    load(3, 1'b1, -1);
    wait_start(ok);
    check("t1_start_seen", 32'(ok), 32'd1);
    check("t1_mem0", 32'(mem[0]), 32'd5);
    check("t1_mem1", 32'(mem[1]), 32'd2);
    check("t1_mem2", 32'(mem[2]), 32'd9);
    bad = 0;
    for (int a = 3; a < DEPTH; a++) if (mem[a] !== 8'hFF) bad++;
    check("t1_pad_fill", 32'(bad), 32'd0);
    check("t1_start_low", 32'(bus.ssc_start), 32'd0);
    pulse_done(100);
    drain("t1_drain");
    check("t1_start_pulses", 32'(start_cnt - s0), 32'd1);
    check("t1_writes", 32'(we_cnt - w0), 32'd256);

    // Full load without in_last: no padding, start right after the last beat.
    for (int i = 0; i < DEPTH; i++) vals[i] = 8'(i * 37 + 11);
    s0 = start_cnt; w0 = we_cnt;
    load(DEPTH, 1'b0, -1);
    @(negedge clk);
    check("t2_in_ready_drop", 32'(bus.in_ready), 32'd0);
    check("t2_start_next", 32'(bus.ssc_start), 32'd1);
    step();
    pulse_done(5);
    drain("t2_drain");
    check("t2_start_pulses", 32'(start_cnt - s0), 32'd1);
    check("t2_writes", 32'(we_cnt - w0), 32'd256);

    // Output stall: data held, no new reads while out_ready is low.
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    bus.out_ready = 1'b0;
    load(4, 1'b1, -1);
    wait_start(ok);
    check("t3_start_seen", 32'(ok), 32'd1);
    pulse_done(3);
    for (c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    check("t3_out_valid", 32'(bus.out_valid), 32'd1);
    for (int k = 0; k < 10; k++) begin
      check("t3_hold_data", 32'(bus.out_data), 32'h11);
      check("t3_hold_valid", 32'(bus.out_valid), 32'd1);
      check("t3_hold_rf_re", 32'(bus.rf_re), 32'd0);
      @(negedge clk);
    end
    step();
    bus.out_ready = 1'b1;
    drain("t3_drain");

    // Sort controller never finishes: watchdog expires, then a new load clears the flag.
    vals[0] = 8'h21; vals[1] = 8'h43;
    o0 = ovld_cnt;
    load(2, 1'b1, -1);
    wait_start(ok);
    check("t4_start_seen", 32'(ok), 32'd1);
    for (c = 1; c <= TMO + 20; c++) begin
      @(negedge clk);
      if (bus.err_timeout) break;
    end
    check("t4_timeout_cycle", 32'(c), 32'(TMO + 1));
    check("t4_busy", 32'(bus.busy), 32'd0);
    check("t4_no_output", 32'(ovld_cnt - o0), 32'd0);
    exp_q.delete();
    step();
    check("t4_err_sticky", 32'(bus.err_timeout), 32'd1);
    vals[0] = 8'h07;
    load(1, 1'b1, -1);
    @(negedge clk);
    check("t4_err_cleared", 32'(bus.err_timeout), 32'd0);
    wait_start(ok);
    check("t4_restart_seen", 32'(ok), 32'd1);
    pulse_done(10);
    drain("t4_drain");

    // Reset while padding after a 40-beat load.
    for (int i = 0; i < 40; i++) vals[i] = 8'(i + 100);
    s0 = start_cnt;
    load(40, 1'b1, -1);
    step();
    @(negedge clk);
    check("t5_padding", 32'(bus.rf_we), 32'd1);
    check("t5_pad_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    w0 = we_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("t5_rst_rf_we", 32'(bus.rf_we), 32'd0);
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    check("t5_rst_rf_own", 32'(bus.rf_own), 32'd1);
    step();
    rst = 1'b0;
    repeat (300) step();
    check("t5_no_start", 32'(start_cnt - s0), 32'd0);
    check("t5_no_writes", 32'(we_cnt - w0), 32'd0);
    exp_q.delete();

    // Stray done pulse during load is ignored.
    vals[0] = 8'h90; vals[1] = 8'h0A; vals[2] = 8'h3C; vals[3] = 8'hFE; vals[4] = 8'h01;
    s0 = start_cnt;
    load(5, 1'b1, 2);
    wait_start(ok);
    check("t6_start_seen", 32'(ok), 32'd1);
    pulse_done(20);
    drain("t6_drain");
    check("t6_start_pulses", 32'(start_cnt - s0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
